// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage. It holds a fetch PC, issues one word read at a time
//    over a req/ack handshake, and buffers {instr, pc} pairs in a DEPTH-entry FIFO for decode.
// Latency: a word acked at edge N appears on instr/instr_valid after edge N. With
//    IFQ_BYPASS_EN defined, a word acked into an empty queue appears in the same cycle.
// Backpressure: no request is issued unless a queue slot is free. An issued request is held,
//    with a stable address, until mem_ack.
// Ports:
//    clk, reset                      : clock and synchronous active-high reset
//    mem_req, mem_addr               : read request and word address to instruction memory
//    mem_ack, mem_rdata              : read completion and returned instruction word
//    instr_valid, instr, instr_pc    : queue head; all outputs are zero while the queue is empty
//    instr_ready                     : consumer pops the head when instr_valid is also high
//    redirect, redirect_addr         : flush the queue and restart fetch at redirect_addr
//    empty                           : queue holds no entries
// Optional feature macro: IFQ_BYPASS_EN (zero-latency path from memory to an empty queue head)
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_addr,
   output logic        empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state, state_nx;
   logic [15:0]   fetch_pc, fetch_pc_nx, addr_nx;
   logic [CW-1:0] count, count_nx;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [15:0]   data_q [DEPTH];
   logic [15:0]   pc_q   [DEPTH];

   logic q_empty, ack_ok, take, push, pop;

   assign q_empty = (count == '0);
   // A returned word is usable only in REQ; in DROP, or alongside a redirect, it is discarded.
   assign ack_ok  = (state == REQ) && mem_ack && !redirect;
`ifdef IFQ_BYPASS_EN
   // The word goes straight to the consumer and never occupies a queue slot.
   assign take    = ack_ok && q_empty && instr_ready;
`else
   assign take    = 1'b0;
`endif
   assign push    = ack_ok && !take;
   // A redirect flushes the queue, so a same-cycle pop has no further effect.
   assign pop     = !q_empty && instr_ready && !redirect;
   assign count_nx = count + CW'(push) - CW'(pop);

   assign mem_req = (state != IDLE);
   assign empty   = q_empty;

   // Next-state logic for the fetch FSM, fetch PC and request address.
   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      addr_nx     = mem_addr;
      if (redirect) begin
         fetch_pc_nx = redirect_addr;
         if (state != IDLE && !mem_ack) begin
            // Outstanding request cannot be aborted: wait out its ack with the old address.
            state_nx = DROP;
         end else begin
            state_nx = REQ;
            addr_nx  = redirect_addr;
         end
      end else begin
         case (state)
            IDLE: begin
               if (count < FULL) begin
                  state_nx = REQ;
                  addr_nx  = fetch_pc;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  fetch_pc_nx = mem_addr + 16'd1;
                  addr_nx     = mem_addr + 16'd1;
                  state_nx    = (count_nx < FULL) ? REQ : IDLE;
               end
            end
            DROP: begin
               if (mem_ack) begin
                  state_nx = REQ;
                  addr_nx  = fetch_pc;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         mem_addr <= RESET_PC;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         mem_addr <= addr_nx;
         if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            count <= count_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Queue storage needs no reset: entries are only read when count says they are valid.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         data_q[wr_ptr] <= mem_rdata;
         pc_q[wr_ptr]   <= mem_addr;
      end
   end

   always_comb begin
      instr_valid = !q_empty;
      instr       = q_empty ? 16'h0000 : data_q[rd_ptr];
      instr_pc    = q_empty ? 16'h0000 : pc_q[rd_ptr];
`ifdef IFQ_BYPASS_EN
      if (q_empty && ack_ok) begin
         instr_valid = 1'b1;
         instr       = mem_rdata;
         instr_pc    = mem_addr;
      end
`endif
   end

endmodule
